// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the on-chip traffic generator and
//                its matching checker. Provides the FSM state type, the
//                LFSR tap constant and the LFSR step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tg_state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Galois LFSR, shift right: the feedback taps are XORed in when the
  // bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr32
//  Description : 32-bit Galois LFSR with synchronous load and step enable.
//                A zero seed would lock the register, so it is replaced by 1.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset (value <= SEED)
//                load   - load seed (takes priority over enable)
//                enable - advance one step
//                seed   - value loaded on load
//                value  - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr32
  import traffic_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hBAADF00D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  localparam logic [31:0] c_reset_value = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= c_reset_value;
    end else if (load) begin
      r_value <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (enable) begin
      r_value <= lfsr_next(r_value);
    end
  end

  assign value = r_value;

endmodule : lfsr32
`default_nettype wire

// File: rtl/traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_gen
//  Description : On-chip packet traffic source. After a start pulse it sends
//                a programmed number of LFSR-derived payload words to a fixed
//                destination over a valid/ready handshake, inserting a
//                programmable idle gap after every accepted word.
//  Ports       : clk          - clock
//                rst_n        - asynchronous active-low reset
//                i_start      - start pulse (honoured in IDLE/DONE only)
//                i_num_pkts   - packets to send, latched on start
//                i_dest       - destination node, latched on start
//                i_gap        - idle cycles after each packet, latched on start
//                o_data_out   - payload word
//                o_dest_out   - destination node
//                o_valid_out  - payload valid
//                o_ready_in   - downstream ready (input)
//                o_busy       - high in SEND and GAP
//                o_done       - high in DONE
//                o_sent_count - handshakes completed in the current run
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_gen
  import traffic_pkg::*;
#(
  parameter int          WIDTH_DATA    = 16,
  parameter int          ADDRESS_WIDTH = 4,
  parameter logic [31:0] SEED          = 32'hBAADF00D,
  parameter int          WIDTH_COUNT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [WIDTH_COUNT-1:0]   i_num_pkts,
  input  logic [ADDRESS_WIDTH-1:0] i_dest,
  input  logic [3:0]               i_gap,
  output logic [WIDTH_DATA-1:0]    o_data_out,
  output logic [ADDRESS_WIDTH-1:0] o_dest_out,
  output logic                     o_valid_out,
  input  logic                     o_ready_in,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [WIDTH_COUNT-1:0]   o_sent_count
);

  localparam logic [31:0] c_seed = (SEED == 32'h0) ? 32'h1 : SEED;

  tg_state_t                r_state;
  logic [WIDTH_COUNT-1:0]   r_num;
  logic [3:0]               r_gap;
  logic [3:0]               r_gap_cnt;
  logic [WIDTH_COUNT-1:0]   r_sent;
  logic [WIDTH_DATA-1:0]    r_data;
  logic [ADDRESS_WIDTH-1:0] r_dest;
  logic                     r_valid;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_start_accept;
  logic                     w_handshake;
  logic                     w_last;
  logic [31:0]              w_lfsr;
  logic [31:0]              w_lfsr_nxt;
  logic [WIDTH_COUNT-1:0]   w_sent_inc;

  assign w_start_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  // r_valid is only ever high in SEND, so no state qualifier is needed.
  assign w_handshake    = r_valid && o_ready_in;
  assign w_sent_inc     = r_sent + 1'b1;
  assign w_last         = (w_sent_inc == r_num);
  assign w_lfsr_nxt     = lfsr_next(w_lfsr);

  lfsr32 #(
    .SEED (c_seed)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_start_accept),
    .enable (w_handshake),
    .seed   (c_seed),
    .value  (w_lfsr)
  );

  // Only the low payload bits of the next LFSR state feed the data register.
  generate
    if (WIDTH_DATA < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_lfsr_nxt[31:WIDTH_DATA];
    end
  endgenerate

  // The payload register mirrors the low LFSR bits: loaded with the seed on
  // start and with the next LFSR value on each handshake, so it stays stable
  // across stalls and reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_num     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_sent    <= '0;
      r_data    <= '0;
      r_dest    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_num     <= i_num_pkts;
            r_gap     <= i_gap;
            r_dest    <= i_dest;
            r_sent    <= '0;
            r_gap_cnt <= '0;
            r_data    <= c_seed[WIDTH_DATA-1:0];
            if (i_num_pkts == '0) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= SEND;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end

        SEND: begin
          if (w_handshake) begin
            r_sent <= w_sent_inc;
            r_data <= w_lfsr_nxt[WIDTH_DATA-1:0];
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap != 4'd0) begin
              r_state   <= GAP;
              r_valid   <= 1'b0;
              r_gap_cnt <= r_gap;
            end
          end
        end

        GAP: begin
          // Counter starts at gap and leaves at 1: exactly gap idle cycles.
          if (r_gap_cnt == 4'd1) begin
            r_state <= SEND;
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out   = r_data;
  assign o_dest_out   = r_dest;
  assign o_valid_out  = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sent_count = r_sent;

endmodule : traffic_gen
`default_nettype wire

// File: tb/tb_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_gen
//  Description : Self-checking bench for traffic_gen. Expected payload/dest
//                words are pushed to a scoreboard when a run is started and
//                popped by a monitor on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_num_pkts;
  logic [3:0]  i_dest;
  logic [3:0]  i_gap;
  logic [15:0] o_data_out;
  logic [3:0]  o_dest_out;
  logic        o_valid_out;
  logic        o_ready_in;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_sent_count;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  traffic_gen #(
    .WIDTH_DATA    (16),
    .ADDRESS_WIDTH (4),
    .SEED          (32'hBAADF00D),
    .WIDTH_COUNT   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_num_pkts   (i_num_pkts),
    .i_dest       (i_dest),
    .i_gap        (i_gap),
    .o_data_out   (o_data_out),
    .o_dest_out   (o_dest_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_sent_count (o_sent_count)
  );

  function automatic logic [31:0] m_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Monitor: sample just after the negedge so inputs driven on that edge are
  // seen exactly as the next posedge will see them.
  always @(negedge clk) begin
    logic [19:0] exp_word;
    #1;
    if (rst_n === 1'b1 && o_valid_out === 1'b1 && o_ready_in === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: handshake dest=%h data=%h, no word expected", o_dest_out, o_data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if ({o_dest_out, o_data_out} !== exp_word) begin
          errors++;
          $display("FAIL sb_word: got dest/data %h, expected %h", {o_dest_out, o_data_out}, exp_word);
        end
      end
    end
  end

  task automatic push_run(input int n, input logic [3:0] d);
    logic [31:0] s;
    s = 32'hBAADF00D;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({d, s[15:0]});
      s = m_next(s);
    end
  endtask

  // Returns at the first negedge after the start pulse was sampled.
  task automatic start_run(input int n, input logic [3:0] d, input logic [3:0] g);
    @(negedge clk);
    i_num_pkts = 16'(n);
    i_dest     = d;
    i_gap      = g;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: o_done=%b after %0d cycles, required 1", o_done, budget);
    end
  endtask

  task automatic test_sb_empty;
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d expected words never seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_valid_out, o_busy, o_done, o_data_out, o_dest_out, o_sent_count} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b b=%b d=%b data=%h dest=%h cnt=%h, required all 0",
               o_valid_out, o_busy, o_done, o_data_out, o_dest_out, o_sent_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid_out !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: v=%b b=%b d=%b, required 0 0 0", o_valid_out, o_busy, o_done);
    end
  endtask

  task automatic test_basic;
    logic [31:0] s3;
    s3 = m_next(m_next(32'hBAADF00D));
    o_ready_in = 1'b1;
    push_run(3, 4'd1);
    start_run(3, 4'd1, 4'd0);
    checks++;
    if (o_valid_out !== 1'b1 || o_data_out !== 16'hF00D || o_dest_out !== 4'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_word0: v=%b data=%h dest=%h busy=%b, required 1 f00d 1 1",
               o_valid_out, o_data_out, o_dest_out, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_valid_out !== 1'b1 || o_data_out !== 16'hF805) begin
      errors++;
      $display("FAIL basic_word1: v=%b data=%h, required 1 f805", o_valid_out, o_data_out);
    end
    @(negedge clk);
    checks++;
    if (o_valid_out !== 1'b1 || o_data_out !== s3[15:0]) begin
      errors++;
      $display("FAIL basic_word2: v=%b data=%h, required 1 %h", o_valid_out, o_data_out, s3[15:0]);
    end
    @(negedge clk);
    checks++;
    if (o_valid_out !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b0 || o_sent_count !== 16'd3) begin
      errors++;
      $display("FAIL basic_done: v=%b done=%b busy=%b cnt=%0d, required 0 1 0 3",
               o_valid_out, o_done, o_busy, o_sent_count);
    end
    test_sb_empty();
  endtask

  task automatic test_gap;
    logic [9:0] pat;
    pat = 10'b1001001001;
    o_ready_in = 1'b1;
    push_run(4, 4'd2);
    start_run(4, 4'd2, 4'd2);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (o_valid_out !== pat[9-i]) begin
        errors++;
        $display("FAIL gap_pattern[%0d]: valid=%b, required %b", i, o_valid_out, pat[9-i]);
      end
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_sent_count !== 16'd4 || o_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: done=%b cnt=%0d v=%b, required 1 4 0", o_done, o_sent_count, o_valid_out);
    end
    test_sb_empty();
  endtask

  task automatic test_stall;
    o_ready_in = 1'b0;
    push_run(2, 4'd3);
    start_run(2, 4'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid_out !== 1'b1 || o_data_out !== 16'hF00D || o_sent_count !== 16'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b data=%h cnt=%0d, required 1 f00d 0",
                 i, o_valid_out, o_data_out, o_sent_count);
      end
      @(negedge clk);
    end
    o_ready_in = 1'b1;
    wait_done(10);
    checks++;
    if (o_sent_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_count: cnt=%0d, required 2", o_sent_count);
    end
    test_sb_empty();
  endtask

  task automatic test_zero;
    o_ready_in = 1'b1;
    start_run(0, 4'd5, 4'd0);
    checks++;
    if (o_done !== 1'b1 || o_valid_out !== 1'b0 || o_sent_count !== 16'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b v=%b cnt=%0d busy=%b, required 1 0 0 0",
               o_done, o_valid_out, o_sent_count, o_busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL zero_novalid[%0d]: valid=%b, required 0", i, o_valid_out);
      end
    end
  endtask

  task automatic test_reset_mid;
    o_ready_in = 1'b1;
    push_run(5, 4'd4);
    start_run(5, 4'd4, 4'd0);
    @(negedge clk);
    checks++;
    if (o_sent_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_pre: cnt=%0d, required 1", o_sent_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid_out !== 1'b0 || o_busy !== 1'b0 || o_sent_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_async: v=%b busy=%b cnt=%0d, required 0 0 0",
               o_valid_out, o_busy, o_sent_count);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_run(2, 4'd4);
    start_run(2, 4'd4, 4'd0);
    checks++;
    if (o_valid_out !== 1'b1 || o_data_out !== 16'hF00D) begin
      errors++;
      $display("FAIL rstmid_replay: v=%b data=%h, required 1 f00d", o_valid_out, o_data_out);
    end
    wait_done(10);
    checks++;
    if (o_sent_count !== 16'd2) begin
      errors++;
      $display("FAIL rstmid_count: cnt=%0d, required 2", o_sent_count);
    end
    test_sb_empty();
  endtask

  task automatic test_restart;
    o_ready_in = 1'b1;
    push_run(3, 4'd6);
    start_run(3, 4'd6, 4'd3);
    @(negedge clk);
    i_start    = 1'b1;
    i_num_pkts = 16'd7;
    i_gap      = 4'd0;
    i_dest     = 4'd9;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_dest_out !== 4'd6) begin
      errors++;
      $display("FAIL restart_ignored: busy=%b dest=%h, required 1 6", o_busy, o_dest_out);
    end
    wait_done(40);
    checks++;
    if (o_sent_count !== 16'd3) begin
      errors++;
      $display("FAIL restart_busy_count: cnt=%0d, required 3", o_sent_count);
    end
    test_sb_empty();
    push_run(2, 4'd7);
    start_run(2, 4'd7, 4'd0);
    checks++;
    if (o_done !== 1'b0 || o_valid_out !== 1'b1 || o_data_out !== 16'hF00D || o_sent_count !== 16'd0) begin
      errors++;
      $display("FAIL restart_from_done: done=%b v=%b data=%h cnt=%0d, required 0 1 f00d 0",
               o_done, o_valid_out, o_data_out, o_sent_count);
    end
    wait_done(10);
    checks++;
    if (o_sent_count !== 16'd2) begin
      errors++;
      $display("FAIL restart_count: cnt=%0d, required 2", o_sent_count);
    end
    test_sb_empty();
  endtask

  initial begin
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_num_pkts = '0;
    i_dest     = '0;
    i_gap      = '0;
    o_ready_in = 1'b0;

    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_zero();
    test_reset_mid();
    test_restart();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_traffic_gen
`default_nettype wire
